// File: rtl/tlul_host_arb_if.sv
// TL-UL request/response structs and the bundle joining N hosts and one device to the arbiter.
// The arbiter takes the slave modport; whoever drives hosts and device takes master.
package tlul_pkg;
  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [1:0]        a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [3:0]        a_mask;
    logic [TL_DW-1:0]  a_data;
    logic [7:0]        a_user;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [1:0]        d_size;
    logic [TL_AIW-1:0] d_source;
    logic              d_sink;
    logic [TL_DW-1:0]  d_data;
    logic [7:0]        d_user;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

  localparam tl_h2d_t TL_H2D_DEFAULT = '0;
  localparam tl_d2h_t TL_D2H_DEFAULT = '0;
endpackage

interface tlul_host_arb_if #(parameter int NumHosts = 2);
  import tlul_pkg::*;
  tl_h2d_t tl_h_i [NumHosts];
  tl_d2h_t tl_h_o [NumHosts];
  tl_h2d_t tl_d_o;
  tl_d2h_t tl_d_i;

  modport slave  (input tl_h_i, input tl_d_i, output tl_h_o, output tl_d_o);
  modport master (output tl_h_i, output tl_d_i, input tl_h_o, input tl_d_o);
endinterface

// File: rtl/tlul_host_arb.sv
// N-to-1 TL-UL host arbiter: grant/lock FSM, a_source tagging, D routing by tag and
// per-host outstanding limits. Define TLUL_HOST_ARB_FAIR_EN for round-robin arbitration.
module tlul_host_arb
  import tlul_pkg::*;
#(
  parameter int  NumHosts       = 2,
  parameter int  MaxOutstanding = 4,
  localparam int IdxW           = $clog2(NumHosts)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  tlul_host_arb_if.slave        bus,
  output logic                  o_dbg_lock,
  output logic [IdxW-1:0]       o_dbg_grant,
  output logic [NumHosts*4-1:0] o_dbg_cnt
);
  // Valid/ready: a beat moves on any cycle where valid and ready are both high; a source
  // holding valid must keep its fields stable until that cycle, ready may come and go freely.
  logic                     r_lock, w_lock_nxt;
  logic [IdxW-1:0]          r_grant, w_grant, w_arb_idx, w_rsp_idx;
  logic [NumHosts-1:0][3:0] r_cnt;
  logic [NumHosts-1:0]      w_elig, w_inc, w_dec;
  logic                     w_any, w_fwd, w_a_hs, w_d_hs, w_rsp_hit, w_d_ready;
  tl_h2d_t                  w_req;
  tl_d2h_t                  w_rsp [NumHosts];

`ifdef TLUL_HOST_ARB_FAIR_EN
  logic [IdxW-1:0] r_rr_ptr;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     r_rr_ptr <= '0;
    else if (w_a_hs) r_rr_ptr <= (int'(w_grant) == NumHosts - 1) ? '0 : w_grant + 1'b1;
  end
`endif

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NumHosts; i++) begin
      w_elig[i] = bus.tl_h_i[i].a_valid && (r_cnt[i] < 4'(MaxOutstanding));
    end
  end

  // Lowest eligible index wins; with round-robin, the lowest one at or above the pointer
  // overrides it, which is the same as a wrapped search starting at the pointer.
  always_comb begin
    w_any     = 1'b0;
    w_arb_idx = '0;
    for (int i = NumHosts - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_any     = 1'b1;
        w_arb_idx = IdxW'(i);
      end
    end
`ifdef TLUL_HOST_ARB_FAIR_EN
    for (int i = NumHosts - 1; i >= 0; i--) begin
      if (w_elig[i] && (IdxW'(i) >= r_rr_ptr)) w_arb_idx = IdxW'(i);
    end
`endif
  end

  // FSM state register: IDLE (r_lock = 0) / LOCKED (r_lock = 1)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lock  <= 1'b0;
      r_grant <= '0;
    end else begin
      r_lock  <= w_lock_nxt;
      r_grant <= w_grant;
    end
  end

  always_comb begin
    w_lock_nxt = r_lock;
    if (!r_lock)                  w_lock_nxt = w_any && !bus.tl_d_i.a_ready;
    else if (bus.tl_d_i.a_ready)  w_lock_nxt = 1'b0;
  end

  always_comb begin
    w_grant   = r_lock ? r_grant : w_arb_idx;
    w_fwd     = r_lock || w_any;
    w_rsp_idx = bus.tl_d_i.d_source[IdxW-1:0];
    w_rsp_hit = int'(w_rsp_idx) < NumHosts;
    // A tag with no matching host is drained so the device never stalls on it.
    w_d_ready = w_rsp_hit ? bus.tl_h_i[w_rsp_idx].d_ready : 1'b1;

    w_req = TL_H2D_DEFAULT;
    if (w_fwd) begin
      w_req          = bus.tl_h_i[w_grant];
      w_req.a_source = {bus.tl_h_i[w_grant].a_source[TL_AIW-1-IdxW:0], w_grant};
    end
    w_req.d_ready = w_d_ready;
    w_a_hs = w_req.a_valid && bus.tl_d_i.a_ready;
    w_d_hs = bus.tl_d_i.d_valid && w_d_ready;

    w_inc = '0;
    w_dec = '0;
    for (int i = 0; i < NumHosts; i++) begin
      w_rsp[i] = TL_D2H_DEFAULT;
      if (w_rsp_hit && (w_rsp_idx == IdxW'(i))) begin
        w_rsp[i]          = bus.tl_d_i;
        w_rsp[i].d_source = bus.tl_d_i.d_source >> IdxW;
      end
      w_rsp[i].a_ready = w_fwd && (w_grant == IdxW'(i)) && bus.tl_d_i.a_ready;
      w_inc[i] = w_a_hs && (w_grant == IdxW'(i));
      w_dec[i] = w_d_hs && w_rsp_hit && (w_rsp_idx == IdxW'(i));
    end
  end

  assign bus.tl_d_o = w_req;
  for (genvar g = 0; g < NumHosts; g++) begin : g_rsp
    assign bus.tl_h_o[g] = w_rsp[g];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < NumHosts; i++) begin
        if (w_inc[i] && !w_dec[i])                          r_cnt[i] <= r_cnt[i] + 4'd1;
        else if (w_dec[i] && !w_inc[i] && r_cnt[i] != 4'd0) r_cnt[i] <= r_cnt[i] - 4'd1;
      end
    end
  end

  assign o_dbg_lock  = r_lock;
  assign o_dbg_grant = w_grant;
  assign o_dbg_cnt   = r_cnt;
endmodule

// File: tb/tb_tlul_host_arb.sv
// Directed bench for tlul_host_arb: a 2-host instance (limit 2) with A/D scoreboards,
// plus a 3-host instance for the out-of-range response tag.
module tb_tlul_host_arb;
  import tlul_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        lock2, lock3;
  logic [0:0]  grant2;
  logic [1:0]  grant3;
  logic [7:0]  cnt2;
  logic [11:0] cnt3;

  int n_checks = 0;
  int n_fail   = 0;

  logic [39:0] exp_a_q[$];  // {tagged a_source, a_address}
  logic [43:0] exp_d_q[$];  // {host, d_source, d_data}

  tlul_host_arb_if #(.NumHosts(2)) bus2 ();
  tlul_host_arb_if #(.NumHosts(3)) bus3 ();

  tlul_host_arb #(.NumHosts(2), .MaxOutstanding(2)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus2),
    .o_dbg_lock(lock2), .o_dbg_grant(grant2), .o_dbg_cnt(cnt2)
  );

  tlul_host_arb #(.NumHosts(3), .MaxOutstanding(4)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus3),
    .o_dbg_lock(lock3), .o_dbg_grant(grant3), .o_dbg_cnt(cnt3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic set_req(input int h, input logic v, input logic [7:0] src, input logic [31:0] addr);
    bus2.tl_h_i[h].a_valid   = v;
    bus2.tl_h_i[h].a_opcode  = 3'd4;
    bus2.tl_h_i[h].a_source  = src;
    bus2.tl_h_i[h].a_address = addr;
    bus2.tl_h_i[h].a_mask    = 4'hf;
  endtask

  task automatic dev_rsp(input logic v, input logic [7:0] src, input logic [31:0] data);
    bus2.tl_d_i.d_valid  = v;
    bus2.tl_d_i.d_opcode = 3'd1;
    bus2.tl_d_i.d_source = src;
    bus2.tl_d_i.d_data   = data;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // A-channel monitor
  always @(negedge clk) begin
    if (bus2.tl_d_o.a_valid && bus2.tl_d_i.a_ready) begin
      if (exp_a_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL a_unexpected: got 0x%0h expected none",
                 {bus2.tl_d_o.a_source, bus2.tl_d_o.a_address});
      end else begin
        check("a_chan", {bus2.tl_d_o.a_source, bus2.tl_d_o.a_address}, exp_a_q.pop_front());
      end
    end
  end

  // D-channel monitor
  always @(negedge clk) begin
    for (int h = 0; h < 2; h++) begin
      if (bus2.tl_h_o[h].d_valid && bus2.tl_h_i[h].d_ready) begin
        if (exp_d_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL d_unexpected: got host %0d src 0x%0h expected none", h, bus2.tl_h_o[h].d_source);
        end else begin
          check("d_chan", {4'(h), bus2.tl_h_o[h].d_source, bus2.tl_h_o[h].d_data}, exp_d_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    for (int h = 0; h < 2; h++) begin
      bus2.tl_h_i[h] = '0;
      bus2.tl_h_i[h].d_ready = 1'b1;
    end
    bus2.tl_d_i = '0;
    bus2.tl_d_i.a_ready = 1'b1;
    for (int h = 0; h < 3; h++) bus3.tl_h_i[h] = '0;
    bus3.tl_d_i = '0;
    bus3.tl_d_i.a_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_a_valid", bus2.tl_d_o.a_valid, 0);
    check("rst_d_valid0", bus2.tl_h_o[0].d_valid, 0);
    check("rst_d_valid1", bus2.tl_h_o[1].d_valid, 0);
    check("rst_a_ready0", bus2.tl_h_o[0].a_ready, 0);
    check("rst_a_ready1", bus2.tl_h_o[1].a_ready, 0);
    check("rst_lock", lock2, 0);
    check("rst_cnt", cnt2, 0);
    next_cycle();
    rst_n = 1'b1;

    // both hosts valid continuously
    next_cycle();
`ifdef TLUL_HOST_ARB_FAIR_EN
    exp_a_q.push_back({8'h02, 32'h100});
    exp_a_q.push_back({8'h05, 32'h200});
    exp_a_q.push_back({8'h02, 32'h100});
    exp_a_q.push_back({8'h05, 32'h200});
`else
    exp_a_q.push_back({8'h02, 32'h100});
    exp_a_q.push_back({8'h02, 32'h100});
    exp_a_q.push_back({8'h05, 32'h200});
    exp_a_q.push_back({8'h05, 32'h200});
`endif
    set_req(0, 1'b1, 8'h01, 32'h100);
    set_req(1, 1'b1, 8'h02, 32'h200);
    repeat (4) next_cycle();
    @(negedge clk);
    check("limit_a_valid", bus2.tl_d_o.a_valid, 0);
    check("limit_a_ready0", bus2.tl_h_o[0].a_ready, 0);
    check("limit_cnt", cnt2, 8'h22);

    // one response frees host 0; it is accepted the next cycle
    next_cycle();
    exp_d_q.push_back({4'd0, 8'h01, 32'hD0});
    dev_rsp(1'b1, 8'h02, 32'hD0);
    @(negedge clk);
    check("gated_a_ready0", bus2.tl_h_o[0].a_ready, 0);
    check("gated_d_ready", bus2.tl_d_o.d_ready, 1);
    next_cycle();
    dev_rsp(1'b0, 8'h00, 32'h0);
    exp_a_q.push_back({8'h02, 32'h100});
    @(negedge clk);
    check("freed_a_ready0", bus2.tl_h_o[0].a_ready, 1);
    next_cycle();
    set_req(0, 1'b0, 8'h00, 32'h0);
    set_req(1, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    check("refill_cnt", cnt2, 8'h22);

    // same-host and cross-host simultaneous A/D handshakes
    next_cycle();
    exp_d_q.push_back({4'd0, 8'h01, 32'hD1});
    dev_rsp(1'b1, 8'h02, 32'hD1);
    next_cycle();
    exp_d_q.push_back({4'd0, 8'h01, 32'hD2});
    dev_rsp(1'b1, 8'h02, 32'hD2);
    exp_a_q.push_back({8'h06, 32'h104});
    set_req(0, 1'b1, 8'h03, 32'h104);
    next_cycle();
    exp_a_q.push_back({8'h08, 32'h108});
    set_req(0, 1'b1, 8'h04, 32'h108);
    exp_d_q.push_back({4'd1, 8'h02, 32'hE1});
    dev_rsp(1'b1, 8'h05, 32'hE1);
    @(negedge clk);
    check("same_host_cnt", cnt2, 8'h21);
    next_cycle();
    set_req(0, 1'b0, 8'h00, 32'h0);
    exp_d_q.push_back({4'd1, 8'h02, 32'hE2});
    dev_rsp(1'b1, 8'h05, 32'hE2);
    @(negedge clk);
    check("cross_host_cnt", cnt2, 8'h12);
    next_cycle();
    exp_d_q.push_back({4'd0, 8'h01, 32'hD3});
    dev_rsp(1'b1, 8'h02, 32'hD3);
    next_cycle();
    exp_d_q.push_back({4'd0, 8'h01, 32'hD4});
    dev_rsp(1'b1, 8'h02, 32'hD4);
    next_cycle();
    dev_rsp(1'b0, 8'h00, 32'h0);
    @(negedge clk);
    check("drained_cnt", cnt2, 8'h00);

    // source tagging round trip for host 1
    next_cycle();
    exp_a_q.push_back({8'h0B, 32'h300});
    set_req(1, 1'b1, 8'h05, 32'h300);
    @(negedge clk);
    check("tag_a_source", bus2.tl_d_o.a_source, 8'h0B);
    next_cycle();
    set_req(1, 1'b0, 8'h00, 32'h0);
    exp_d_q.push_back({4'd1, 8'h05, 32'hAB});
    dev_rsp(1'b1, 8'h0B, 32'hAB);
    @(negedge clk);
    check("tag_d_valid0", bus2.tl_h_o[0].d_valid, 0);
    check("tag_d_valid1", bus2.tl_h_o[1].d_valid, 1);
    check("tag_d_source1", bus2.tl_h_o[1].d_source, 8'h05);
    next_cycle();
    dev_rsp(1'b0, 8'h00, 32'h0);

    // lock: host 1 stalled 3 cycles while host 0 becomes valid
    bus2.tl_d_i.a_ready = 1'b0;
    exp_a_q.push_back({8'h0D, 32'h500});
    exp_a_q.push_back({8'h0E, 32'h400});
    set_req(1, 1'b1, 8'h06, 32'h500);
    @(negedge clk);
    check("lock_src_c0", bus2.tl_d_o.a_source, 8'h0D);
    next_cycle();
    set_req(0, 1'b1, 8'h07, 32'h400);
    @(negedge clk);
    check("lock_src_c1", bus2.tl_d_o.a_source, 8'h0D);
    check("lock_flag", lock2, 1);
    check("lock_a_ready0", bus2.tl_h_o[0].a_ready, 0);
    next_cycle();
    @(negedge clk);
    check("lock_src_c2", bus2.tl_d_o.a_source, 8'h0D);
    next_cycle();
    bus2.tl_d_i.a_ready = 1'b1;
    next_cycle();
    set_req(1, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    check("unlock_flag", lock2, 0);
    next_cycle();
    set_req(0, 1'b0, 8'h00, 32'h0);

    // asynchronous reset while LOCKED
    bus2.tl_d_i.a_ready = 1'b0;
    set_req(0, 1'b1, 8'h08, 32'h600);
    next_cycle();
    @(negedge clk);
    check("pre_rst_lock", lock2, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_lock", lock2, 0);
    check("async_rst_cnt", cnt2, 8'h00);
    set_req(0, 1'b0, 8'h00, 32'h0);
    bus2.tl_d_i.a_ready = 1'b1;
    next_cycle();
    rst_n = 1'b1;

    // in-flight response after reset: routed by tag, counter saturates
    exp_d_q.push_back({4'd1, 8'h06, 32'hF0});
    dev_rsp(1'b1, 8'h0D, 32'hF0);
    next_cycle();
    dev_rsp(1'b0, 8'h00, 32'h0);
    @(negedge clk);
    check("sat_cnt", cnt2, 8'h00);

    // 3-host instance: tag 3 is drained, tag 2 is routed
    bus3.tl_d_i.d_valid  = 1'b1;
    bus3.tl_d_i.d_source = 8'h03;
    bus3.tl_d_i.d_data   = 32'h33;
    @(negedge clk);
    check("drain_d_ready", bus3.tl_d_o.d_ready, 1);
    check("drain_d_valid0", bus3.tl_h_o[0].d_valid, 0);
    check("drain_d_valid1", bus3.tl_h_o[1].d_valid, 0);
    check("drain_d_valid2", bus3.tl_h_o[2].d_valid, 0);
    next_cycle();
    bus3.tl_d_i.d_source = 8'h0A;
    @(negedge clk);
    check("route3_d_ready", bus3.tl_d_o.d_ready, 0);
    check("route3_d_valid2", bus3.tl_h_o[2].d_valid, 1);
    check("route3_d_source2", bus3.tl_h_o[2].d_source, 8'h02);
    next_cycle();
    bus3.tl_d_i.d_valid = 1'b0;
    @(negedge clk);
    check("route3_cnt", cnt3, 12'h000);

    repeat (2) next_cycle();
    check("exp_a_empty", exp_a_q.size(), 0);
    check("exp_d_empty", exp_d_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tlul_host_arb.md
# tlul_host_arb

N-to-1 TL-UL host arbiter that shares one downstream device port between N upstream hosts using the `tlul_pkg` `tl_h2d_t`/`tl_d2h_t` structs. It arbitrates A-channel requests and tags `a_source` with the host index. It routes D-channel responses back by that tag and tracks per-host outstanding transactions to enforce a fixed limit. It sits between multiple hosts (core I/D ports, DMA) and a single crossbar or device socket.

## Interface
- `NumHosts`, default 2: number of upstream hosts, range 2..8.
- `MaxOutstanding`, default 4: maximum in-flight requests per host, range 1..15.
- `IdxW`, default `$clog2(NumHosts)` (localparam): width of the source tag.
- `clk_i  input  1`: clock.
- `rst_ni  input  1`: asynchronous active-low reset.
- `tl_h_i  input  tl_h2d_t [NumHosts]`: host requests.
- `tl_h_o  output  tl_d2h_t [NumHosts]`: host responses and `a_ready`.
- `tl_d_o  output  tl_h2d_t`: request to the device.
- `tl_d_i  input  tl_d2h_t`: response from the device.

## Operation
- **Eligible host:** host i is eligible when `tl_h_i[i].a_valid` is high and `cnt[i] < MaxOutstanding`.
- **States:** one per arbiter, IDLE and LOCKED, held in a lock flag.
- **IDLE:**
  - Grant goes to the first eligible host searching from `rr_ptr` upward, modulo `NumHosts`. With the fair macro off, the search starts at index 0.
  - If any host is eligible, forward its request to `tl_d_o`, combinationally.
  - If no host is eligible, `tl_d_o.a_valid` = 0 and the other fields are `TL_H2D_DEFAULT`.
  - If `tl_d_i.a_ready` = 0 while `a_valid` = 1, go to LOCKED and register the grant.
- **LOCKED:** the registered grant is held. No re-arbitration happens until the A handshake completes; the grant holds even if a higher-priority host becomes valid. On handshake, return to IDLE.
- **Pointer update:** on every A handshake, `rr_ptr` <= (grant + 1) mod `NumHosts`.
- **Source tagging, request:** `tl_d_o.a_source` = {`a_source[TL_AIW-1-IdxW:0]`, grant index}. All other A fields pass unmodified, including `a_user`.
- **Source tagging, response:** `d_source` to the host = `tl_d_i.d_source >> IdxW`. The upper IdxW bits are returned as zero. Hosts must use only the low `TL_AIW-IdxW` source bits.
- **Request ready:** `tl_h_o[i].a_ready` = `tl_d_i.a_ready` for the granted host, 0 for all others.
- **Response routing:** `rsp_idx` = `tl_d_i.d_source[IdxW-1:0]`.
  - `tl_h_o[rsp_idx]` gets `d_valid` and all D fields.
  - Other hosts see `d_valid` = 0, with D fields from `TL_D2H_DEFAULT`.
  - `tl_d_o.d_ready` = `tl_h_i[rsp_idx].d_ready`.
  - If `rsp_idx` >= `NumHosts`, `d_ready` is forced to 1 to drain, and no host sees the response.
- **Outstanding counters:** `cnt[i]` is 4 bits.
  - +1 on an A handshake for host i.
  - −1 on a D handshake routed to host i.
  - Both in the same cycle: unchanged.
  - Decrement when the count is 0: stays 0 (saturates).
- **Combinational paths:** arbitration and routing are purely combinational from inputs and registers.

## Timing
- **Latency:** A-channel 0 cycles; D-channel 0 cycles. No buffering is added.
- **Reset values:** lock = 0, `rr_ptr` = 0, all `cnt` = 0.
- **Outputs during reset, all hosts idle:** `tl_d_o.a_valid` = 0; all `tl_h_o[i].d_valid` = 0; all `tl_h_o[i].a_ready` = 0.
- **Simultaneous A and D events:** an A and a D handshake in the same cycle for different hosts update both counters independently.
- **Limit-gated host:** a host at `MaxOutstanding` becomes eligible on the cycle after its D handshake.
- **Reset mid-transaction:** lock and counters clear immediately. In-flight responses arriving afterwards are still routed by tag; their counters saturate at 0.
- **Hosts:** must hold A fields stable while `a_valid` = 1 and `a_ready` = 0, per TL-UL.

## Configuration
- `TLUL_HOST_ARB_FAIR_EN`
  - Defined: round-robin search starting at `rr_ptr`, as described above.
  - Undefined: fixed priority with host 0 highest; `rr_ptr` is not implemented.
- Lock and outstanding-limit behaviour are identical in both builds.

## Test plan
- **Round-robin:** hosts 0 and 1 both valid continuously, device `a_ready` = 1, fair macro on. Grants must alternate 0,1,0,1.
  - Same stimulus with the macro off: host 0 is always granted.
- **Lock:** host 1 granted, device `a_ready` low for 3 cycles, host 0 raises `a_valid` in cycle 1. `tl_d_o` holds host 1's request for all 3 cycles; host 0 is granted only after host 1's handshake.
- **Source tagging:** host 1 sends `a_source` 0x05 with `NumHosts` = 2. Device sees 0x0B. Device responds with `d_source` 0x0B; only host 1 sees `d_valid`, with `d_source` 0x05.
- **Outstanding limit:** `MaxOutstanding` = 2, host 0 issues 3 requests with no responses. The third request sees `a_ready` = 0 and `cnt[0]` = 2. After one D handshake the third is accepted on the next cycle.
- **Simultaneous and boundary:** a host-0 A handshake and a host-0 D handshake in the same cycle leave `cnt[0]` unchanged. A response with tag 3 when `NumHosts` = 3 is drained with `d_ready` = 1 and no host `d_valid`.
- **Reset mid-operation:** assert `rst_ni` = 0 while LOCKED. Lock is 0 and all counters are 0 in the same cycle, asynchronously.
